// File: rtl/bayer_frame_server.sv
// Single-frame Bayer store: streams in one 128x128 CFA frame,
// then serves three concurrent 1-cycle-latency read ports.
module bayer_frame_server #(
    parameter int N_PAT = 16384,
    parameter int AW    = 15,
    parameter int AW1   = 14,
    parameter int DW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic           pix_valid,
    input  logic [DW-1:0]  pix_data,
    output logic           load_ready,
    output logic           bayer_ready,
    input  logic           bayer_req,
    input  logic [AW-1:0]  bayer_addr,
    input  logic [AW1-1:0] bayer_addr_1,
    input  logic [AW1-1:0] bayer_addr_2,
    output logic [DW-1:0]  bayer_data,
    output logic [DW-1:0]  bayer_data_1,
    output logic [DW-1:0]  bayer_data_2,
    input  logic           finish
);

    localparam int CW = $clog2(N_PAT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] wr_cnt, wr_cnt_d;
    logic          wr_en;
    logic          serve_go;
    logic          addr_ok;

    logic [DW-1:0] mem [N_PAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
        end else begin
            state  <= state_d;
            wr_cnt <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        wr_cnt_d = wr_cnt;
        wr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end
            end
            LOAD: begin
                // a restart pulse takes priority over a pixel on the same cycle
                if (load_start) begin
                    wr_cnt_d = '0;
                end else if (pix_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt + 1'b1;
                    if (wr_cnt == CW'(N_PAT - 1)) begin
                        state_d  = SERVE;
                        wr_cnt_d = '0;
                    end
                end
            end
            SERVE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end else if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= pix_data;
        end
    end

    assign load_ready  = (state == LOAD);
    assign bayer_ready = (state == SERVE);

    // Reads only land while staying in SERVE, so leaving SERVE zeroes the ports
    assign serve_go = (state == SERVE) && (state_d == SERVE);
    assign addr_ok  = (bayer_addr < AW'(N_PAT));

    always_ff @(posedge clk) begin
        if (rst || !serve_go) begin
            bayer_data   <= '0;
            bayer_data_1 <= '0;
            bayer_data_2 <= '0;
        end else if (bayer_req) begin
            if (addr_ok) begin
                bayer_data <= mem[bayer_addr[CW-1:0]];
            end
            bayer_data_1 <= mem[bayer_addr_1];
            bayer_data_2 <= mem[bayer_addr_2];
        end else begin
            bayer_data   <= '0;
            bayer_data_1 <= '0;
        end
    end

endmodule

// File: tb/tb_bayer_frame_server.sv
// Randomized scoreboard bench for bayer_frame_server against a
// behavioural frame/read model.
module tb_bayer_frame_server;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        load_ready;
    logic        bayer_ready;
    logic        bayer_req;
    logic [14:0] bayer_addr;
    logic [13:0] bayer_addr_1;
    logic [13:0] bayer_addr_2;
    logic [7:0]  bayer_data;
    logic [7:0]  bayer_data_1;
    logic [7:0]  bayer_data_2;
    logic        finish;

    bayer_frame_server dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .load_ready   (load_ready),
        .bayer_ready  (bayer_ready),
        .bayer_req    (bayer_req),
        .bayer_addr   (bayer_addr),
        .bayer_addr_1 (bayer_addr_1),
        .bayer_addr_2 (bayer_addr_2),
        .bayer_data   (bayer_data),
        .bayer_data_1 (bayer_data_1),
        .bayer_data_2 (bayer_data_2),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       lr;
        logic       br;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // Reference model: frame contents, load pointer and mode
    localparam int M_IDLE = 0, M_LOAD = 1, M_SERVE = 2, M_DONE = 3;
    int         m_mode = M_IDLE;
    int         m_wr = 0;
    logic [7:0] m_mem [N];
    logic [7:0] m_d0 = 8'h00, m_d1 = 8'h00, m_d2 = 8'h00;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc || load_ready !== e.lr || bayer_ready !== e.br ||
                bayer_data !== e.d0 || bayer_data_1 !== e.d1 ||
                bayer_data_2 !== e.d2) begin
                errors++;
                $display("FAIL out cyc=%0d got lr=%b br=%b d=%h/%h/%h want lr=%b br=%b d=%h/%h/%h",
                         cyc, load_ready, bayer_ready, bayer_data, bayer_data_1,
                         bayer_data_2, e.lr, e.br, e.d0, e.d1, e.d2);
            end
        end
    end

    // Apply current inputs for one clock; predict what follows the edge
    task automatic tick();
        int   nm;
        exp_t x;
        nm = m_mode;
        if (rst) begin
            nm   = M_IDLE;
            m_wr = 0;
        end else begin
            case (m_mode)
                M_LOAD: begin
                    if (load_start) m_wr = 0;
                    else if (pix_valid) begin
                        m_mem[m_wr] = pix_data;
                        if (m_wr == N - 1) begin
                            nm   = M_SERVE;
                            m_wr = 0;
                        end else m_wr++;
                    end
                end
                M_SERVE: begin
                    if (load_start) begin
                        nm   = M_LOAD;
                        m_wr = 0;
                    end else if (finish) nm = M_DONE;
                end
                default: begin
                    if (load_start) begin
                        nm   = M_LOAD;
                        m_wr = 0;
                    end
                end
            endcase
        end
        if (rst || m_mode != M_SERVE || nm != M_SERVE) begin
            m_d0 = 8'h00;
            m_d1 = 8'h00;
            m_d2 = 8'h00;
        end else if (bayer_req) begin
            if (int'(bayer_addr) < N) m_d0 = m_mem[int'(bayer_addr)];
            m_d1 = m_mem[int'(bayer_addr_1)];
            m_d2 = m_mem[int'(bayer_addr_2)];
        end else begin
            m_d0 = 8'h00;
            m_d1 = 8'h00;
        end
        m_mode = nm;
        x.due = cyc + 1;
        x.lr  = (nm == M_LOAD);
        x.br  = (nm == M_SERVE);
        x.d0  = m_d0;
        x.d1  = m_d1;
        x.d2  = m_d2;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst          = 1'b0;
        load_start   = 1'b0;
        pix_valid    = 1'b0;
        pix_data     = 8'h00;
        bayer_req    = 1'b0;
        bayer_addr   = '0;
        bayer_addr_1 = '0;
        bayer_addr_2 = '0;
        finish       = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // kind 0: data = index, 1: random, 2: inverted index
    task automatic load_frame(input int kind, input bit gaps);
        int n;
        n = 0;
        while (n < N) begin
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (kind)
                0:       pix_data = 8'(n);
                1:       pix_data = 8'($urandom);
                default: pix_data = ~8'(n);
            endcase
            tick();
            if (pix_valid) n++;
        end
        pix_valid = 1'b0;
    endtask

    task automatic rd(input logic req, input logic [14:0] a0,
                      input logic [13:0] a1, input logic [13:0] a2);
        bayer_req    = req;
        bayer_addr   = a0;
        bayer_addr_1 = a1;
        bayer_addr_2 = a2;
        tick();
    endtask

    task automatic rand_reads(input int n);
        logic [14:0] a0;
        for (int i = 0; i < n; i++) begin
            a0 = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(N, 32767))
                                             : 15'($urandom_range(0, N - 1));
            rd($urandom_range(0, 3) != 0, a0, 14'($urandom), 14'($urandom));
        end
    endtask

    initial begin
        int p;
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        pulse_load();
        load_frame(0, 1'b0);
        tick();

        rd(1'b1, 15'h0081, 14'h0080, 14'h3FFF);
        rd(1'b1, 15'd5, 14'd7, 14'd9);
        rd(1'b1, 15'd16384, 14'd10, 14'd11);
        rd(1'b1, 15'd32767, 14'd12, 14'd13);
        rd(1'b1, 15'd1, 14'd2, 14'h003C);
        rd(1'b0, 15'd3, 14'd4, 14'd5);
        rd(1'b0, 15'd6, 14'd7, 14'd8);
        rd(1'b1, 15'd200, 14'd200, 14'd200);
        rand_reads(300);

        // Partial load with gaps, interrupted by reset
        bayer_req = 1'b0;
        pulse_load();
        p = 0;
        for (int i = 0; i < 200 && p < 100; i++) begin
            pix_valid = i[0];
            pix_data  = 8'($urandom);
            if (pix_valid && p == 60) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                break;
            end
            tick();
            if (pix_valid) p++;
        end
        pix_valid = 1'b0;
        tick();
        tick();

        pulse_load();
        load_frame(1, 1'b1);
        rd(1'b1, 15'd59, 14'd59, 14'd59);
        rand_reads(200);

        // Finish, ignored requests, then reload
        finish = 1'b1;
        rd(1'b1, 15'd10, 14'd11, 14'd12);
        finish = 1'b0;
        rd(1'b1, 15'd20, 14'd21, 14'd22);
        rd(1'b1, 15'd30, 14'd31, 14'd32);
        pulse_load();
        load_frame(2, 1'b0);
        rand_reads(100);

        // load_start beats finish in the same cycle
        load_start = 1'b1;
        finish     = 1'b1;
        rd(1'b1, 15'd1, 14'd2, 14'd3);
        load_start = 1'b0;
        finish     = 1'b0;
        rd(1'b1, 15'd4, 14'd5, 14'd6);
        quiet();
        tick();
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
